// File: rtl/uart_rx_mon_pkg.sv
// Shared types for the UART receive monitor: FSM states and the FIFO entry layout.
package uart_mon_pkg;

  localparam int unsigned DATA_W_MAX = 9;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} mon_state_t;

  typedef struct packed {
    logic                  ferr;
    logic                  perr;
    logic [DATA_W_MAX-1:0] data;
  } mon_entry_t;

endpackage

// File: rtl/uart_rx_mon_fifo.sv
// First-word fall-through FIFO with occupancy level, reusable by other monitors.
module mon_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(depth):0] level,
  output logic                   drop
);
  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign valid   = (level != '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & valid;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = valid ? mem[rptr] : '0;

  always_ff @(posedge hclk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mon.sv
// UART receive monitor: synchronises rx, decodes frames against a runtime divider,
// and buffers {ferr, perr, data} entries for a valid/ready consumer.
module uart_rx_mon
  import uart_mon_pkg::*;
#(
  parameter int unsigned data_w  = 8,
  parameter int unsigned dfr_w   = 16,
  parameter int unsigned fifo_d  = 8,
  parameter int unsigned sync_st = 2
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    en,
  input  logic [dfr_w-1:0]        dfr,
  input  logic                    par_en,
  input  logic                    par_odd,
  input  logic                    stop2,
  input  logic                    rx,
  output logic [data_w-1:0]       rd_data,
  output logic                    rd_perr,
  output logic                    rd_ferr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [$clog2(fifo_d):0] fifo_lvl,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  logic [sync_st-1:0] sync_q;
  logic               rx_s, rx_d, fall;
  mon_state_t         state;
  logic [dfr_w-1:0]   cnt, dv;
  logic               pe_q, po_q, s2_q;
  logic [3:0]         bit_idx;
  logic [data_w-1:0]  shreg;
  logic               perr_q, ferr_q;
  logic               mid, last_stop, push, drop, fifo_full;
  mon_entry_t         push_ent, head;
  logic               unused_bits;

  assign rx_s = sync_q[sync_st-1];
  assign fall = rx_d & ~rx_s;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[sync_st-2:0], rx};
      rx_d   <= rx_s;
    end
  end

  assign mid       = (cnt == (dv >> 1));
  assign last_stop = ~s2_q | (bit_idx == 4'd1);
  assign push      = en & (state == STOP) & mid & last_stop;

  always_comb begin
    push_ent      = '0;
    push_ent.data = DATA_W_MAX'(shreg);
    push_ent.perr = perr_q;
    push_ent.ferr = ferr_q | ~rx_s;
  end

  // Counter free-runs modulo dv, so each sample after the start mid-point
  // lands exactly one bit period later.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      cnt     <= '0;
      dv      <= dfr_w'(2);
      pe_q    <= 1'b0;
      po_q    <= 1'b0;
      s2_q    <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      cnt <= (cnt == dv - 1'b1) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (fall) begin
          state   <= START;
          cnt     <= '0;
          dv      <= (dfr < dfr_w'(2)) ? dfr_w'(2) : dfr;
          pe_q    <= par_en;
          po_q    <= par_odd;
          s2_q    <= stop2;
          bit_idx <= '0;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
        end
        START: if (mid) state <= rx_s ? IDLE : DATA;
        DATA: if (mid) begin
          shreg <= {rx_s, shreg[data_w-1:1]};
          if (bit_idx == 4'(data_w - 1)) begin
            bit_idx <= '0;
            state   <= pe_q ? PAR : STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        PAR: if (mid) begin
          perr_q <= ((^shreg) ^ rx_s) != po_q;
          state  <= STOP;
        end
        STOP: if (mid) begin
          ferr_q <= ferr_q | ~rx_s;
          if (last_stop) state <= IDLE;
          else           bit_idx <= bit_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)     ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  mon_fifo #(
    .width($bits(mon_entry_t)),
    .depth(fifo_d)
  ) u_fifo (
    .hclk    (hclk),
    .hresetn (hresetn),
    .push    (push),
    .wdata   (push_ent),
    .pop     (rd_ready),
    .rdata   (head),
    .valid   (rd_valid),
    .full    (fifo_full),
    .level   (fifo_lvl),
    .drop    (drop)
  );

  assign rd_data     = head.data[data_w-1:0];
  assign rd_perr     = head.perr;
  assign rd_ferr     = head.ferr;
  assign unused_bits = ^{head.data, fifo_full};

endmodule
